// File: rtl/tdm_demux8.sv
// TDM_DEMUX8: serial time-division demultiplexer.
// Collects eight serial slots, one per accepted beat, into a parallel byte.
// A sync beat always marks slot 0. A completed frame is presented on 'a'
// together with a single out_valid pulse. A frame that is broken, either by
// an early sync or by an over-long idle gap, is dropped and frame_err pulses.
`timescale 1ns/1ps

module tdm_demux8 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       in_valid,
  input  logic       sync,
  output logic [7:0] a,
  output logic       out_valid,
  output logic [2:0] sel,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The timer aborts the frame on the idle cycle that would take it to
  // TIMEOUT. That is the idle cycle on which it already holds TIMEOUT-1.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [2:0]  slot_q;
  logic [6:0]  shadow_q;
  logic [7:0]  idleTimer_q;
  logic [7:0]  a_q;
  logic        outValid_q;
  logic        frameErr_q;
  logic [7:0]  idleTimer_d;

  // Next idle-timer value for an in_valid=0 cycle while a frame is open.
  always_comb begin
    idleTimer_d = idleTimer_q + 8'd1;
  end

  // Frame FSM with its slot counter, shadow bits, idle timer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= 3'd0;
      shadow_q    <= 7'd0;
      idleTimer_q <= 8'd0;
      a_q         <= 8'd0;
      outValid_q  <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      outValid_q <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          idleTimer_q <= 8'd0;
          if (in_valid && sync) begin
            shadow_q <= {6'd0, din};
            slot_q   <= 3'd1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            idleTimer_q <= 8'd0;
            if (sync) begin
              frameErr_q <= 1'b1;
              shadow_q   <= {6'd0, din};
              slot_q     <= 3'd1;
            end else if (slot_q == 3'd7) begin
              a_q        <= {din, shadow_q};
              outValid_q <= 1'b1;
              slot_q     <= 3'd0;
              state_q    <= IDLE;
            end else begin
              shadow_q[slot_q] <= din;
              slot_q           <= slot_q + 3'd1;
            end
          end else if (idleTimer_q == TimeoutLast) begin
            frameErr_q  <= 1'b1;
            slot_q      <= 3'd0;
            idleTimer_q <= 8'd0;
            state_q     <= IDLE;
          end else begin
            idleTimer_q <= idleTimer_d;
          end
        end
        default: begin
          state_q <= IDLE;
          slot_q  <= 3'd0;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign out_valid = outValid_q;
  assign frame_err = frameErr_q;
  assign sel       = slot_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed testbench for tdm_demux8 with the default TIMEOUT of 15.
`timescale 1ns/1ps

module tb_tdm_demux8;

  logic       clk;
  logic       rst;
  logic       din;
  logic       in_valid;
  logic       sync;
  logic [7:0] a;
  logic       out_valid;
  logic [2:0] sel;
  logic       busy;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastPulse = 0;

  tdm_demux8 #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .in_valid  (in_valid),
    .sync      (sync),
    .a         (a),
    .out_valid (out_valid),
    .sel       (sel),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter, used to measure the spacing between out_valid pulses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // out_valid and frame_err must never be high together. Checked mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(out_valid && frame_err)) else begin
        errors++;
        $error("[TB] FAIL pulse_exclusive observed ov=%0b ferr=%0b expected not both 1", out_valid, frame_err);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge. Return 1 ns after the
  // rising edge, so the effect of that beat is visible on the outputs.
  task automatic applyStimulus(input logic v, input logic s, input logic d);
    @(negedge clk);
    in_valid = v;
    sync     = s;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output port at once.
  task automatic checkAll(input string tag, input logic [7:0] expA, input logic expOv,
                          input logic [2:0] expSel, input logic expBusy, input logic expErr);
    checkOutput({tag, ".a"},         a,                 expA);
    checkOutput({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, expOv});
    checkOutput({tag, ".sel"},       {5'd0, sel},       {5'd0, expSel});
    checkOutput({tag, ".busy"},      {7'd0, busy},      {7'd0, expBusy});
    checkOutput({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, expErr});
  endtask

  logic [7:0] pat;

  initial begin
    rst      = 1'b1;
    din      = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    #1;
    // Reset must already hold every output at zero.
    checkAll("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll("post_reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);

    // A basic frame with bits 1,0,1,1,0,0,1,0. sel walks 1..7 after each beat.
    pat = 8'b01001101;
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b1, (j == 0), pat[j]);
      if (j < 7) begin
        checkOutput("basic.sel",  {5'd0, sel},  8'(j + 1));
        checkOutput("basic.busy", {7'd0, busy}, 8'd1);
      end
    end
    checkAll("basic.done", 8'b01001101, 1'b1, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("basic.hold", 8'b01001101, 1'b0, 3'd0, 1'b0, 1'b0);

    // Eight one-hot frames sent back to back. Pulses must be 8 cycles apart.
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 8; s++) begin
        applyStimulus(1'b1, (s == 0), (s == k));
      end
      checkOutput("onehot.a",  a,                 8'(8'd1 << k));
      checkOutput("onehot.ov", {7'd0, out_valid}, 8'd1);
      if (k > 0) checkOutput("onehot.gap", 8'(cyc - lastPulse), 8'd8);
      lastPulse = cyc;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("onehot.pulse_end", {7'd0, out_valid}, 8'd0);

    // Sync arrives again on the slot-4 beat. The partial frame is dropped.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("resync.sel_before", {5'd0, sel}, 8'd4);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkAll("resync.err", 8'h80, 1'b0, 3'd1, 1'b1, 1'b1);
    pat = 8'b11001100;
    for (int j = 1; j < 8; j++) applyStimulus(1'b1, 1'b0, pat[j]);
    checkAll("resync.done", 8'hCD, 1'b1, 3'd0, 1'b0, 1'b0);

    // Sync on the slot-7 beat takes priority over completing the frame.
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int j = 1; j < 7; j++) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("sync7.sel_before", {5'd0, sel}, 8'd7);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkAll("sync7.err", 8'hCD, 1'b0, 3'd1, 1'b1, 1'b1);

    // A 14-cycle gap is tolerated, and the frame then completes.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (14) applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("gap14.open", 8'hCD, 1'b0, 3'd3, 1'b1, 1'b0);
    pat = 8'b10001000;
    for (int j = 3; j < 8; j++) applyStimulus(1'b1, 1'b0, pat[j]);
    checkAll("gap14.done", 8'h8D, 1'b1, 3'd0, 1'b0, 1'b0);

    // A 15-cycle gap aborts the frame.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (14) applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("gap15.before", 8'h8D, 1'b0, 3'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("gap15.abort", 8'h8D, 1'b0, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkAll("gap15.idle_ignore", 8'h8D, 1'b0, 3'd0, 1'b0, 1'b0);

    // Reset arrives asynchronously while the frame sits at slot 5.
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int j = 1; j < 5; j++) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("rst.sel_before", {5'd0, sel}, 8'd5);
    #2;
    rst = 1'b1;
    #1;
    checkAll("rst.async", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkAll("rst.nosync_ignored", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int j = 1; j < 8; j++) applyStimulus(1'b1, 1'b0, 1'b1);
    checkAll("rst.next_frame", 8'hFE, 1'b1, 3'd0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
